// File: rtl/l2_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// l2_port_arbiter_if
// Bundles the two L1 request channels, the L2 command port and the arbiter
// status outputs shared by l2_port_arbiter and its environment.
//
// Signals:
//   req0_rd/req0_wr/req0_addr  requester 0 (I-side) line request, level
//   req1_rd/req1_wr/req1_addr  requester 1 (D-side) line request, level
//   gnt0/gnt1                  port ownership
//   done0/done1                one-cycle completion pulses
//   l2_read/l2_write/l2_addr/l2_beat  L2 command for the current beat
//   l2_ack                     L2 accepted/returned the current beat
//   busy/err                   arbiter active, timeout abort pulse
//
// Modports:
//   slave   the arbiter itself
//   master  the environment (L1 controllers plus L2)
// -----------------------------------------------------------------------------
interface l2_port_arbiter_if #(
   parameter int unsigned BEAT_BITS = 3
);
   logic                 req0_rd;
   logic                 req0_wr;
   logic [31:0]          req0_addr;
   logic                 req1_rd;
   logic                 req1_wr;
   logic [31:0]          req1_addr;
   logic                 gnt0;
   logic                 gnt1;
   logic                 done0;
   logic                 done1;
   logic                 l2_read;
   logic                 l2_write;
   logic [31:0]          l2_addr;
   logic [BEAT_BITS-1:0] l2_beat;
   logic                 l2_ack;
   logic                 busy;
   logic                 err;

   modport slave (
      input  req0_rd, req0_wr, req0_addr, req1_rd, req1_wr, req1_addr, l2_ack,
      output gnt0, gnt1, done0, done1, l2_read, l2_write, l2_addr, l2_beat, busy, err
   );

   modport master (
      output req0_rd, req0_wr, req0_addr, req1_rd, req1_wr, req1_addr, l2_ack,
      input  gnt0, gnt1, done0, done1, l2_read, l2_write, l2_addr, l2_beat, busy, err
   );
endinterface

// File: rtl/l2_port_arbiter.sv
// -----------------------------------------------------------------------------
// l2_port_arbiter
// Shares one L2 request port between two L1 cache controllers. A grant runs a
// full line burst of BEATS word transfers, walking the word address, and ends
// with a one-cycle done pulse to the owner. Ties between the two requesters are
// broken round-robin; requester 0 wins the first tie after reset.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    l2_port_arbiter_if.slave: request channels, L2 command port, status
//
// Optional feature (macro L2_ARB_TIMEOUT_EN): abort a burst after TIMEOUT
// consecutive cycles without l2_ack; done<n> and err pulse together. Without
// the macro no timeout counter exists and err is tied to 0.
// -----------------------------------------------------------------------------
module l2_port_arbiter #(
   parameter int unsigned BEATS     = 8,
   parameter int unsigned BEAT_BITS = 3,
   parameter int unsigned TIMEOUT   = 64,
   parameter int unsigned TO_BITS   = 7
) (
   input logic              clk,
   input logic              reset,
   l2_port_arbiter_if.slave bus
);
   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StXfer = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam int unsigned LineBits = 32 - BEAT_BITS - 2;

   if ((BEATS != (1 << BEAT_BITS)) || (TIMEOUT == 0) || (TIMEOUT >= (1 << TO_BITS)))
   begin : g_param_check
      $error("l2_port_arbiter: inconsistent BEATS/BEAT_BITS or TIMEOUT/TO_BITS");
   end

   logic [1:0]           r_state, w_state_nxt;
   logic                 r_owner, w_owner_nxt;
   logic                 r_op_wr, w_op_wr_nxt;
   logic [LineBits-1:0]  r_line,  w_line_nxt;
   logic [BEAT_BITS-1:0] r_beat,  w_beat_nxt;
   // Requester served by the most recent burst; reset to 1 so 0 wins first tie.
   logic                 r_last,  w_last_nxt;

   logic w_act0, w_act1, w_pick1, w_last_beat, w_timeout, w_xfer;

   assign w_act0      = bus.req0_rd | bus.req0_wr;
   assign w_act1      = bus.req1_rd | bus.req1_wr;
   assign w_pick1     = w_act1 & (~w_act0 | ~r_last);
   assign w_last_beat = (r_beat == BEAT_BITS'(BEATS - 1));
   assign w_xfer      = (r_state == StXfer);

`ifdef L2_ARB_TIMEOUT_EN
   logic [TO_BITS-1:0] r_to;
   logic               r_err;

   assign w_timeout = w_xfer & ~bus.l2_ack & (r_to == TO_BITS'(TIMEOUT - 1));

   // Counts consecutive stalled XFER cycles; anything else clears it, which
   // also covers entry to XFER.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_to  <= '0;
         r_err <= 1'b0;
      end else begin
         r_err <= w_timeout;
         if (w_xfer && !bus.l2_ack && !w_timeout) begin
            r_to <= r_to + TO_BITS'(1);
         end else begin
            r_to <= '0;
         end
      end
   end

   assign bus.err = r_err;
`else
   assign w_timeout = 1'b0;
   assign bus.err   = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_op_wr_nxt = r_op_wr;
      w_line_nxt  = r_line;
      w_beat_nxt  = r_beat;
      w_last_nxt  = r_last;
      case (r_state)
         StIdle: begin
            if (w_act0 || w_act1) begin
               w_state_nxt = StXfer;
               w_owner_nxt = w_pick1;
               // rd+wr together: the write-back goes first, read on a later grant
               w_op_wr_nxt = w_pick1 ? bus.req1_wr : bus.req0_wr;
               w_line_nxt  = w_pick1 ? bus.req1_addr[31:BEAT_BITS+2]
                                     : bus.req0_addr[31:BEAT_BITS+2];
               w_beat_nxt  = '0;
            end
         end
         StXfer: begin
            if (bus.l2_ack) begin
               w_beat_nxt = r_beat + BEAT_BITS'(1);  // wraps to 0 after the last beat
               if (w_last_beat) begin
                  w_state_nxt = StDone;
               end
            end else if (w_timeout) begin
               w_state_nxt = StDone;
               w_beat_nxt  = '0;
            end
         end
         StDone: begin
            w_state_nxt = StIdle;
            w_last_nxt  = r_owner;
         end
         default: begin
            w_state_nxt = StIdle;
            w_beat_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StIdle;
         r_owner <= 1'b0;
         r_op_wr <= 1'b0;
         r_line  <= '0;
         r_beat  <= '0;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_op_wr <= w_op_wr_nxt;
         r_line  <= w_line_nxt;
         r_beat  <= w_beat_nxt;
         r_last  <= w_last_nxt;
      end
   end

   // Outputs decode registered state only; nothing passes through from inputs.
   assign bus.gnt0     = w_xfer & ~r_owner;
   assign bus.gnt1     = w_xfer &  r_owner;
   assign bus.done0    = (r_state == StDone) & ~r_owner;
   assign bus.done1    = (r_state == StDone) &  r_owner;
   assign bus.l2_read  = w_xfer & ~r_op_wr;
   assign bus.l2_write = w_xfer &  r_op_wr;
   assign bus.l2_addr  = w_xfer ? {r_line, r_beat, 2'b00} : 32'h0;
   assign bus.l2_beat  = w_xfer ? r_beat : '0;
   assign bus.busy     = (r_state != StIdle);
endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single L2 request port between two L1 cache controllers (requester 0 = instruction-side, requester 1 = data-side).
- Sequences one line-sized burst of BEATS word transfers per grant and walks the word address across the burst.
- Reports completion to the owning requester.
- Sits between the L1 cache controllers' read_l2/write_l2 request outputs and the L2 cache.

Parameters:
- BEATS, 8, words per line transfer; must be a power of two.
- BEAT_BITS, 3, log2(BEATS); width of the beat counter.
- TIMEOUT, 64, cycles without l2_ack before abort (used only with the optional feature).
- TO_BITS, 7, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req0_rd  input  1  requester 0 line-read (allocate) request; level, held until done0
- req0_wr  input  1  requester 0 line-write (write-back) request; level, held until done0
- req0_addr  input  32  requester 0 line address; stable while request is held
- req1_rd  input  1  requester 1 line-read request
- req1_wr  input  1  requester 1 line-write request
- req1_addr  input  32  requester 1 line address
- gnt0  output  1  requester 0 owns the L2 port
- gnt1  output  1  requester 1 owns the L2 port
- done0  output  1  one-cycle pulse: requester 0 transfer complete
- done1  output  1  one-cycle pulse: requester 1 transfer complete
- l2_read  output  1  L2 read command, valid during a read burst
- l2_write  output  1  L2 write command, valid during a write burst
- l2_addr  output  32  current beat word address
- l2_beat  output  BEAT_BITS  current beat index
- l2_ack  input  1  L2 accepted or returned the current beat
- busy  output  1  arbiter not in IDLE
- err  output  1  one-cycle pulse: transfer aborted by timeout; constant 0 without the optional feature

Behaviour:
- Reset is asynchronous and may assert at any cycle, including mid-burst.
  - State goes to IDLE; beat counter and timeout counter clear to 0.
  - Round-robin pointer resets so requester 0 wins the first tie.
  - Every output is driven to 0.
- All outputs are registered; none depend combinationally on inputs.
- States: IDLE, XFER, DONE.
- IDLE:
  - A requester is active when its rd or wr input is 1.
  - If exactly one requester is active, it wins.
  - If both are active, the winner is the requester not served last.
  - At the winning edge: latch owner, operation and address; set gnt<n>; go to XFER.
  - If the owner has both rd and wr asserted, write wins; the read is served by a later grant.
  - Grant latency is 1 cycle: gnt<n>=1 in the cycle after the request is first seen in IDLE.
- XFER:
  - l2_read or l2_write is 1, matching the latched operation.
  - l2_addr = {latched_addr[31:BEAT_BITS+2], beat, 2'b00}.
  - l2_beat = beat.
  - On each cycle with l2_ack=1, beat increments.
  - l2_ack=0 stalls indefinitely; all outputs hold.
  - On l2_ack=1 with beat==BEATS-1, go to DONE; beat wraps to 0.
- DONE:
  - done<n>=1 for exactly one cycle; gnt, l2_read and l2_write are 0.
  - Round-robin pointer records the owner.
  - Return to IDLE.
  - A new request may be granted at the earliest on the cycle after DONE, so there is a minimum 1-cycle bubble between bursts.
- Request inputs are sampled only in IDLE. A requester dropping rd/wr during XFER does not cancel the burst; it completes normally.
- l2_ack in IDLE or DONE is ignored.
- gnt0 and gnt1 are never 1 simultaneously; l2_read and l2_write are never 1 simultaneously.
- busy = 1 in XFER and DONE.

Optional Feature:
- Macro: L2_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on every l2_ack and on entry to XFER, and increments each XFER cycle with l2_ack=0.
  - When it reaches TIMEOUT, the arbiter goes to DONE; done<n> and err both pulse 1 for that cycle.
  - The beat counter clears, and the round-robin pointer updates as for a normal completion.
- Not defined: no counter is built, err is tied to 0, and a stall lasts until l2_ack.

Test Plan:
- Single read: req0_rd=1, req0_addr=0x0000_1234, l2_ack=1 every cycle.
  - gnt0 rises 1 cycle later.
  - l2_read=1 for 8 cycles with l2_addr 0x1220, 0x1224, … 0x123C and l2_beat 0..7.
  - done0 pulses once, then IDLE.
- Tie and round-robin: req0_rd and req1_wr asserted together and held.
  - Requester 0 is served first and requester 1 second, with one idle cycle between.
  - Re-asserting both afterwards grants requester 0 again, since 1 was served last.
- Write priority and stalls: req1_rd=1 and req1_wr=1 with l2_ack pattern 1,0,0,1,…
  - l2_write=1 and l2_read=0 throughout.
  - The beat advances only on ack cycles; l2_addr holds during stalls.
- Request drop and spurious ack: req0_rd deasserted at beat 3.
  - All 8 beats still complete and done0 pulses.
  - l2_ack=1 in IDLE causes no state change.
- Reset mid-burst: reset asserted at beat 5, asynchronously mid-cycle.
  - All outputs are 0 immediately.
  - After release, with both requesters active, requester 0 wins.
- Timeout (L2_ARB_TIMEOUT_EN): req1_rd=1, one ack, then l2_ack held 0.
  - After 64 stall cycles, err and done1 pulse together and l2_read drops.
